bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit tri-state data bus.
- Sources on the bus include the constant ROM, register outputs and ALU result.
- Accepts bus requests from NUM_REQ drivers and issues at most one registered one-hot output-enable at a time.
- Inserts dead (turnaround) cycles between owners so two tri-state drivers never overlap.

Parameters:
- NUM_REQ, 4: number of bus drivers/requesters (2..8).
- TURN_CYCLES, 1: idle cycles with all enables low after a grant ends (1..3).
- MAX_HOLD, 16: maximum consecutive grant cycles when another requester waits (timeout build only).

Ports:
- clk  input  1  rising-edge clock.
- reset_to_constant_val  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  per-driver request; held high for as long as the driver needs the bus.
- bus_en  output  NUM_REQ  one-hot (or zero) tri-state enable, wired to each driver's enable.
- grant_valid  output  1  high whenever bus_en is non-zero.
- grant_id  output  clog2(NUM_REQ)  index of current owner; 0 when grant_valid low.
- bus_busy  output  1  high in GRANT or TURNAROUND state.
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Reset (async):
  - bus_en=0, grant_valid=0, grant_id=0, bus_busy=0, timeout=0.
  - State IDLE; round-robin pointer=NUM_REQ-1, so req[0] wins first.
  - Reset asserted mid-grant drops bus_en immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from req to bus_en.
- States: IDLE, GRANT, TURNAROUND.
- IDLE:
  - If req!=0 at a clock edge, pick the first set bit searching upward, with wrap-around, from pointer+1.
  - On that edge: bus_en[w]=1, grant_id=w, pointer=w, go to GRANT. Latency req→enable is 1 edge.
  - If req==0, stay in IDLE.
- GRANT:
  - Hold the owner while req[owner]=1. Other requests are ignored (non-preemptive).
  - Edge sampling req[owner]=0: bus_en=0, load turn counter with TURN_CYCLES-1, go to TURNAROUND.
- TURNAROUND:
  - All enables low; decrement the counter each cycle.
  - At 0, go to IDLE. Arbitration happens only in IDLE.
  - Zero-enable gap between consecutive owners is TURN_CYCLES+1 cycles.
- Requests arriving or dropping during TURNAROUND are simply sampled again in IDLE; there is no latching.
- A requester that deasserts before being granted is not granted.
- Simultaneous requests resolve by round-robin only; no requester is granted twice while another waits.
- Single requester held continuously: grant, release, turnaround and re-grant follow the normal sequence.
- bus_en is guaranteed one-hot-or-zero in every cycle. The bench asserts this.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A hold counter of width clog2(MAX_HOLD+1) counts GRANT cycles.
  - On the edge where the count reaches MAX_HOLD while any other req bit is high: revoke (bus_en=0, go to TURNAROUND) and pulse timeout for one cycle.
  - The pointer stays at the revoked owner, so it is searched last.
  - With no competing request, the counter saturates and the grant is kept.
- When undefined: no counter; grants last until release; timeout is tied 0. The port is present in both builds.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (IDLE, GRANT, TURNAROUND);
  - localparam width helpers (ID_W = clog2(NUM_REQ));
  - the default TURN_CYCLES/MAX_HOLD constants.
- Sub-module rr_picker: purely combinational. Inputs req and pointer; outputs winner index and any_req. Reused by future memory-port arbitration.

Test Plan:
- Reset with req=4'b1111:
  - After reset release, first edge gives bus_en=0001, grant_id=0.
  - Owners then cycle 0→1→2→3→0 as each drops and reasserts req.
  - With TURN_CYCLES=1, there are exactly 2 zero-enable cycles between grants.
- req=4'b0100 alone, held 5 cycles then dropped:
  - bus_en=0100 one edge after assert, for 5 cycles.
  - Then bus_en=0000 and bus_busy high for 1 cycle, then IDLE.
- Assert reset_to_constant_val asynchronously mid-GRANT (owner 2): bus_en→0000 before the next clk edge; after release, the first winner is req[0].
- req[1] rises during TURNAROUND after owner 3 releases: granted at the first IDLE edge (pointer 3 wraps to 0 then 1; req[0]=0).
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=16, req=4'b0011 held:
  - Owner 0 is revoked after 16 grant cycles with a 1-cycle timeout pulse.
  - Owner 1 is granted after the turnaround.
  - Same stimulus without the macro: owner 0 holds indefinitely and timeout stays 0.
- Random req for 10k cycles: bus_en never has more than one bit set; every requester held high is granted within NUM_REQ grants.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the tri-state bus arbiter and its round-robin picker.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_TURNAROUND = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TURN_CYCLES = 1;
    localparam int DEF_MAX_HOLD    = 16;
    localparam int ID_W            = $clog2(DEF_NUM_REQ);

    // Index width for n items, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from pointer+1, with wrap.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    // Candidate gi is the requester gi+1 places after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            localparam int OFF = gi + 1;
            assign cand_idx[gi] = ID_W'((int'(pointer) + OFF) % NUM_REQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    assign any_req = |req;

    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared tri-state data bus with dead cycles between owners.
// Optional forced revocation of long grants is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD    = DEF_MAX_HOLD
`endif
) (
    input  logic                       clk,
    input  logic                       reset_to_constant_val,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         bus_en,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       bus_busy,
    output logic                       timeout
);

    localparam int IDW    = width_for(NUM_REQ);
    localparam int TURN_W = width_for(TURN_CYCLES);

    arb_state_t         state_reg, state_next;
    logic [IDW-1:0]     pointer_reg, pointer_next;
    logic [IDW-1:0]     grant_id_reg, grant_id_next;
    logic [NUM_REQ-1:0] bus_en_reg, bus_en_next;
    logic [TURN_W-1:0]  turn_cnt_reg, turn_cnt_next;
    logic [IDW-1:0]     winner;
    logic [NUM_REQ-1:0] winner_onehot;
    logic               any_req;
    logic               owner_req;
    logic               revoke;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IDW)
    ) u_picker (
        .req     (req),
        .pointer (pointer_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == IDW'(gi));
        end
    endgenerate

    assign owner_req = req[grant_id_reg];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              timeout_reg;

    // Revoke only when the owner has used its full allowance and someone else is waiting.
    assign revoke = (hold_cnt_reg == HOLD_W'(MAX_HOLD)) && (|(req & ~bus_en_reg));

    always_comb begin
        hold_cnt_next = '0;
        if (state_next == ST_GRANT) begin
            if (state_reg != ST_GRANT) begin
                hold_cnt_next = HOLD_W'(1);
            end else if (hold_cnt_reg != HOLD_W'(MAX_HOLD)) begin
                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end else begin
                hold_cnt_next = hold_cnt_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_to_constant_val) begin
        if (reset_to_constant_val) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= (state_reg == ST_GRANT) && owner_req && revoke;
        end
    end

    assign timeout = timeout_reg;
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        pointer_next  = pointer_reg;
        grant_id_next = grant_id_reg;
        bus_en_next   = bus_en_reg;
        turn_cnt_next = turn_cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next    = ST_GRANT;
                    pointer_next  = winner;
                    grant_id_next = winner;
                    bus_en_next   = winner_onehot;
                end
            end
            ST_GRANT: begin
                if (!owner_req || revoke) begin
                    state_next    = ST_TURNAROUND;
                    grant_id_next = '0;
                    bus_en_next   = '0;
                    turn_cnt_next = TURN_W'(TURN_CYCLES - 1);
                end
            end
            ST_TURNAROUND: begin
                if (turn_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg - TURN_W'(1);
                end
            end
            default: begin
                state_next    = ST_IDLE;
                grant_id_next = '0;
                bus_en_next   = '0;
            end
        endcase
    end

    // Asynchronous reset so the drivers release the bus without waiting for a clock.
    always_ff @(posedge clk or posedge reset_to_constant_val) begin
        if (reset_to_constant_val) begin
            state_reg    <= ST_IDLE;
            pointer_reg  <= IDW'(NUM_REQ - 1);
            grant_id_reg <= '0;
            bus_en_reg   <= '0;
            turn_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pointer_reg  <= pointer_next;
            grant_id_reg <= grant_id_next;
            bus_en_reg   <= bus_en_next;
            turn_cnt_reg <= turn_cnt_next;
        end
    end

    assign bus_en      = bus_en_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = |bus_en_reg;
    assign bus_busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner-case sequences, random run vs reference model.
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] bus_en;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         bus_busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_REQ     (N),
        .TURN_CYCLES (TURN)
    ) dut (
        .clk                   (clk),
        .reset_to_constant_val (rst),
        .req                   (req),
        .bus_en                (bus_en),
        .grant_valid           (grant_valid),
        .grant_id              (grant_id),
        .bus_busy              (bus_busy),
        .timeout               (timeout)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl[13];

    // Reference model state: current owner (-1 = none), dead edges left, last winner, cycles owned.
    int   m_owner, m_gap, m_ptr, m_held;
    logic m_to;

    function automatic logic [8:0] mk(input logic [3:0] en, input logic [1:0] id,
                                      input logic to, input logic busy);
        return {en, id, |en, busy, to};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {bus_en, grant_id, grant_valid, bus_busy, timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got en=%b id=%0d valid=%b busy=%b to=%b, want en=%b id=%0d valid=%b busy=%b to=%b",
                     name, act[8:5], act[4:3], act[2], act[1], act[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        req = r;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", mk(4'b0000, 2'd0, 1'b0, 1'b0));
        #2 rst = 1'b0;
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_gap   = 0;
        m_ptr   = N - 1;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic m_step(input logic [N-1:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = TURN;
            end else if (TO_EN && m_held >= MAX_HOLD && (r & ~(N'(1) << m_owner)) != '0) begin
                m_owner = -1;
                m_gap   = TURN;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [8:0] m_expect();
        logic [3:0] en;
        logic [1:0] id;
        en = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return mk(en, id, m_to, (m_owner >= 0) || (m_gap > 0));
    endfunction

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bus_en)) begin
            errors++;
            $display("FAIL onehot: got bus_en=%b, want at most one bit set", bus_en);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        int           hold_left [N];
        int           wait_cnt  [N];
        logic         prev_valid;
        int           old_owner;

        rst = 1'b1;
        req = '0;

        // Round-robin rotation with all four requesting; owners drop and re-raise in turn.
        tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b1110, 4'b0000, 2'd0, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b1101, 4'b0000, 2'd0, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{4'b1011, 4'b0000, 2'd0, 1'b1};
        tbl[8]  = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b1111, 4'b1000, 2'd3, 1'b1};
        tbl[10] = '{4'b0111, 4'b0000, 2'd0, 1'b1};
        tbl[11] = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[12] = '{4'b1111, 4'b0001, 2'd0, 1'b1};

        do_reset(4'b1111);
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            step();
            check($sformatf("rr_row%0d", i), mk(tbl[i].en, tbl[i].id, 1'b0, tbl[i].busy));
        end

        // Lone requester 2 held for five grant cycles, then released.
        do_reset(4'b0000);
        req = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("single_hold%0d", i), mk(4'b0100, 2'd2, 1'b0, 1'b1));
        end
        req = 4'b0000;
        step();
        check("single_turn", mk(4'b0000, 2'd0, 1'b0, 1'b1));
        step();
        check("single_idle", mk(4'b0000, 2'd0, 1'b0, 1'b0));

        // Asynchronous reset in the middle of owner 2's grant.
        do_reset(4'b0100);
        step();
        check("pre_async_owner2", mk(4'b0100, 2'd2, 1'b0, 1'b1));
        #2;
        req = 4'b1111;
        rst = 1'b1;
        #1;
        check("async_reset_drop", mk(4'b0000, 2'd0, 1'b0, 1'b0));
        #2 rst = 1'b0;
        step();
        check("post_reset_first", mk(4'b0001, 2'd0, 1'b0, 1'b1));

        // Request 1 rises while owner 3's turnaround is in progress.
        do_reset(4'b1000);
        step();
        check("owner3", mk(4'b1000, 2'd3, 1'b0, 1'b1));
        req = 4'b0000;
        step();
        check("owner3_turn", mk(4'b0000, 2'd0, 1'b0, 1'b1));
        req = 4'b0010;
        step();
        check("turn_to_idle", mk(4'b0000, 2'd0, 1'b0, 1'b0));
        step();
        check("late_req1_grant", mk(4'b0010, 2'd1, 1'b0, 1'b1));

        // Two requesters held continuously: revoked after MAX_HOLD only in the timeout build.
        do_reset(4'b0011);
        for (int c = 1; c <= 25; c++) begin
            logic [8:0] e;
`ifdef BUS_ARB_TIMEOUT_EN
            if (c <= 16)      e = mk(4'b0001, 2'd0, 1'b0, 1'b1);
            else if (c == 17) e = mk(4'b0000, 2'd0, 1'b1, 1'b1);
            else if (c == 18) e = mk(4'b0000, 2'd0, 1'b0, 1'b0);
            else              e = mk(4'b0010, 2'd1, 1'b0, 1'b1);
`else
            e = mk(4'b0001, 2'd0, 1'b0, 1'b1);
`endif
            step();
            check($sformatf("hold_cycle%0d", c), e);
        end

        // Random traffic against the reference model, plus a fairness bound on waiting requesters.
        do_reset(4'b0000);
        m_reset();
        r          = '0;
        prev_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            hold_left[i] = 0;
            wait_cnt[i]  = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if (hold_left[i] == 0) r[i] = 1'b0;
                    else hold_left[i]--;
                end else if (r[i]) begin
                    if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            req       = r;
            old_owner = m_owner;
            m_step(r);
            if (m_owner >= 0 && m_owner != old_owner) hold_left[m_owner] = int'($urandom_range(0, 4));
            step();
            check($sformatf("rand_cyc%0d", cyc), m_expect());

            for (int i = 0; i < N; i++) begin
                if (!r[i]) wait_cnt[i] = 0;
            end
            if (grant_valid && !prev_valid) begin
                int worst;
                worst = 0;
                for (int i = 0; i < N; i++) begin
                    if (r[i] && (int'(grant_id) != i)) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
                checks++;
                if (worst >= N) begin
                    errors++;
                    $display("FAIL fairness cyc%0d: got %0d grants to others while waiting, want at most %0d",
                             cyc, worst, N - 1);
                end
            end
            prev_valid = grant_valid;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
